// File: rtl/writeback_pipe_if.sv
// Write-back handshake bundle: upstream result side (in_*, source select/data) and
// register-file side (rf_*, cc). The DUT takes the slave view; the producer/consumer takes master.
interface writeback_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int AW    = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SELW-1:0]       W_Control;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [AW-1:0]         dr;
    logic                  wen;
    logic                  rf_valid;
    logic                  rf_ready;
    logic                  rf_we;
    logic [AW-1:0]         rf_waddr;
    logic [WIDTH-1:0]      rf_wdata;
    logic [2:0]            cc;

    modport slave (
        input  in_valid, W_Control, src_data, dr, wen, rf_ready,
        output in_ready, rf_valid, rf_we, rf_waddr, rf_wdata, cc
    );

    modport master (
        output in_valid, W_Control, src_data, dr, wen, rf_ready,
        input  in_ready, rf_valid, rf_we, rf_waddr, rf_wdata, cc
    );
endinterface

// File: rtl/writeback_pipe.sv
// Source-select + DEPTH-entry write-back FIFO; 1-cycle latency to head; in_ready = not full (never from rf_ready).
// Head held stable under rf_ready=0; optional condition codes built with WRITEBACK_CC_EN (cc reads 000 otherwise).
module writeback_pipe #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    writeback_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [WIDTH-1:0] sel_dat;

    logic             mem_wen [DEPTH];
    logic [AW-1:0]    mem_dr  [DEPTH];
    logic [WIDTH-1:0] mem_dat [DEPTH];

    // Unpopulated select codes read as all ones.
    always_comb begin
        sel_dat = '1;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.W_Control == SELW'(k))
                sel_dat = bus.src_data[k*WIDTH +: WIDTH];
        end
    end

    assign bus.in_ready = (count < CW'(DEPTH));
    assign bus.rf_valid = (count != '0);
    assign push         = bus.in_valid && bus.in_ready && !flush;
    assign pop          = bus.rf_valid && bus.rf_ready && !flush;

    // Head fields are gated so an empty or freshly reset buffer presents zeros.
    assign bus.rf_waddr = bus.rf_valid ? mem_dr[rd_ptr]  : '0;
    assign bus.rf_wdata = bus.rf_valid ? mem_dat[rd_ptr] : '0;
    assign bus.rf_we    = bus.rf_valid && mem_wen[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_wen[wr_ptr] <= bus.wen;
            mem_dr[wr_ptr]  <= bus.dr;
            mem_dat[wr_ptr] <= sel_dat;
        end
    end

`ifdef WRITEBACK_CC_EN
    logic [2:0] cc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cc_q <= 3'b010;
        end else if (pop && bus.rf_we) begin
            if (bus.rf_wdata[WIDTH-1])     cc_q <= 3'b100;
            else if (bus.rf_wdata == '0)   cc_q <= 3'b010;
            else                           cc_q <= 3'b001;
        end
    end

    assign bus.cc = cc_q;
`else
    assign bus.cc = 3'b000;
`endif
endmodule

// File: tb/tb_writeback_pipe.sv
// Randomized + directed bench for writeback_pipe against a queue-based reference model.
module tb_writeback_pipe;
    localparam int W  = 16;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int AW = 3;
    localparam int D  = 2;
`ifdef WRITEBACK_CC_EN
    localparam logic [2:0] CC_RST = 3'b010;
`else
    localparam logic [2:0] CC_RST = 3'b000;
`endif

    typedef struct {
        logic          wen;
        logic [AW-1:0] dr;
        logic [W-1:0]  dat;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    writeback_pipe_if #(.WIDTH(W), .NSRC(NS), .SELW(SW), .AW(AW)) bus ();
    writeback_pipe_if #(.WIDTH(W), .NSRC(3),  .SELW(SW), .AW(AW)) bus3 ();

    writeback_pipe #(.WIDTH(W), .NSRC(NS), .SELW(SW), .AW(AW), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus.slave)
    );
    writeback_pipe #(.WIDTH(W), .NSRC(3), .SELW(SW), .AW(AW), .DEPTH(D)) dut3 (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus3.slave)
    );

    int total = 0;
    int bad   = 0;

    ent_t       q[$];
    logic [2:0] cc_m;
    logic [W-1:0] srcs [NS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [SW-1:0] c);
        if (int'(c) < NS) return srcs[c];
        return {W{1'b1}};
    endfunction

    function automatic logic [2:0] cc_of(input logic [W-1:0] v);
        if (v[W-1])   return 3'b100;
        if (v == '0)  return 3'b010;
        return 3'b001;
    endfunction

    // One clock: drive inputs at negedge, compare against model, then advance model with the edge.
    task automatic step(input logic v, input logic [SW-1:0] c, input logic [AW-1:0] d,
                        input logic w, input logic rr, input logic fl);
        ent_t e;
        bit   full;
        @(negedge clock);
        bus.in_valid  = v;
        bus.W_Control = c;
        bus.dr        = d;
        bus.wen       = w;
        bus.rf_ready  = rr;
        flush         = fl;
        for (int k = 0; k < NS; k++) bus.src_data[k*W +: W] = srcs[k];
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < D));
        check("rf_valid", 32'(bus.rf_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("rf_waddr", 32'(bus.rf_waddr), 32'(q[0].dr));
            check("rf_wdata", 32'(bus.rf_wdata), 32'(q[0].dat));
            check("rf_we",    32'(bus.rf_we),    32'(q[0].wen));
        end else begin
            check("rf_we_idle", 32'(bus.rf_we), 32'd0);
        end
        check("cc", 32'(bus.cc), 32'(cc_m));
        full = (q.size() >= D);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rr) begin
                e = q.pop_front();
`ifdef WRITEBACK_CC_EN
                if (e.wen) cc_m = cc_of(e.dat);
`endif
            end
            if (v && !full) begin
                e.wen = w; e.dr = d; e.dat = pick(c);
                q.push_back(e);
            end
        end
        @(posedge clock);
    endtask

    logic [W-1:0] sweep_exp [4];
    logic [W-1:0] v3;
    logic         w3;

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        bus.in_valid = 0; bus.W_Control = '0; bus.src_data = '0; bus.dr = '0;
        bus.wen = 0; bus.rf_ready = 0;
        bus3.in_valid = 0; bus3.W_Control = '0; bus3.src_data = '0; bus3.dr = '0;
        bus3.wen = 0; bus3.rf_ready = 1;
        for (int k = 0; k < NS; k++) srcs[k] = '0;
        cc_m = CC_RST;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rf_valid", 32'(bus.rf_valid), 32'd0);
        check("rst_rf_we",    32'(bus.rf_we),    32'd0);
        check("rst_waddr",    32'(bus.rf_waddr), 32'd0);
        check("rst_wdata",    32'(bus.rf_wdata), 32'd0);
        check("rst_cc",       32'(bus.cc),       32'(CC_RST));
        @(negedge clock);
        reset = 1'b1;

        // Select sweep with a free-running sink.
        srcs[0] = 16'h1111; srcs[1] = 16'h2222; srcs[2] = 16'h3333; srcs[3] = 16'h4444;
        sweep_exp[0] = 16'h1111; sweep_exp[1] = 16'h2222;
        sweep_exp[2] = 16'h3333; sweep_exp[3] = 16'h4444;
        for (int c = 0; c < 4; c++) begin
            step(1, SW'(c), AW'(c + 1), 1, 1, 0);
            #1 check("sweep", 32'(bus.rf_wdata), 32'(sweep_exp[c]));
        end
        step(0, 0, 0, 0, 1, 0);

        // Backpressure: third push refused, drain in order.
        step(1, 0, 3'd1, 1, 0, 0);
        step(1, 1, 3'd2, 0, 0, 0);
        #1 check("bp_full", 32'(bus.in_ready), 32'd0);
        step(1, 2, 3'd3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        #1 check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        check("bp_second_head", 32'(bus.rf_waddr), 32'd2);
        step(0, 0, 0, 0, 1, 0);
        #1 check("bp_drained", 32'(bus.rf_valid), 32'd0);

        // Flush with full buffer and a push offered the same cycle.
        step(1, 0, 3'd4, 1, 0, 0);
        step(1, 1, 3'd5, 1, 0, 0);
        step(1, 2, 3'd6, 1, 1, 1);
        #1 check("flush_valid", 32'(bus.rf_valid), 32'd0);
        check("flush_ready", 32'(bus.in_ready), 32'd1);
        step(0, 0, 0, 0, 1, 0);

`ifdef WRITEBACK_CC_EN
        srcs[0] = 16'h8000; step(1, 0, 1, 1, 1, 0); step(0, 0, 0, 0, 1, 0);
        #1 check("cc_neg", 32'(bus.cc), 32'b100);
        srcs[0] = 16'h0000; step(1, 0, 1, 1, 1, 0); step(0, 0, 0, 0, 1, 0);
        #1 check("cc_zero", 32'(bus.cc), 32'b010);
        srcs[0] = 16'h0005; step(1, 0, 1, 1, 1, 0); step(0, 0, 0, 0, 1, 0);
        #1 check("cc_pos", 32'(bus.cc), 32'b001);
        srcs[0] = 16'h8000; step(1, 0, 1, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
        #1 check("cc_hold", 32'(bus.cc), 32'b001);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NS; k++) srcs[k] = W'($urandom);
            step(1'($urandom), SW'($urandom), AW'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        // Reset mid-stall with a full buffer: immediate clear, no stray strobe after release.
        step(1, 0, 3'd7, 1, 0, 0);
        step(1, 1, 3'd6, 1, 0, 0);
        @(negedge clock);
        bus.in_valid = 0;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rf_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_we",    32'(bus.rf_we),    32'd0);
        check("mid_rst_cc",    32'(bus.cc),       32'(CC_RST));
        q.delete();
        cc_m = CC_RST;
        @(negedge clock);
        reset = 1'b1;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Three-source instance: select codes beyond NSRC read all ones.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            w3 = 1'($urandom);
            for (int k = 0; k < 3; k++) bus3.src_data[k*W +: W] = W'(16'h0100 * (k + 1) + c);
            v3 = (c < 3) ? W'(16'h0100 * (c + 1) + c) : 16'hFFFF;
            bus3.in_valid  = 1;
            bus3.W_Control = SW'(c);
            bus3.dr        = AW'(c);
            bus3.wen       = w3;
            @(posedge clock);
            #1;
            check("nsrc3_wdata", 32'(bus3.rf_wdata), 32'(v3));
            check("nsrc3_we",    32'(bus3.rf_we),    32'(w3));
            @(negedge clock);
            bus3.in_valid = 0;
            @(posedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
